// File: rtl/lt100_bus_arbiter.sv
// ============================================================================
// lt100_bus_arbiter : two-master arbiter for the Little Timmy 100 common bus,
// round-robin or fixed priority. Optional watchdog: `define ARB_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module lt100_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_enable,
    input  logic                    m0_wr_en,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_i_data,
    input  logic [DATA_WIDTH/8-1:0] m0_be,
    output logic                    m0_ready,
    output logic [DATA_WIDTH-1:0]   m0_o_data,
    output logic                    m0_bus_err,
    input  logic                    m1_enable,
    input  logic                    m1_wr_en,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_i_data,
    input  logic [DATA_WIDTH/8-1:0] m1_be,
    output logic                    m1_ready,
    output logic [DATA_WIDTH-1:0]   m1_o_data,
    output logic                    m1_bus_err,
    output logic                    s_enable,
    output logic                    s_wr_en,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_i_data,
    output logic [DATA_WIDTH/8-1:0] s_be,
    input  logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_o_data,
    input  logic                    s_bus_err,
    output logic [1:0]              grant
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       owner;        // 0 = M0, 1 = M1
    logic       next_owner;
    logic       last_owner;
    logic       own_en;
    logic       capture;
    logic       timeout_hit;
    logic       release_bus;

    assign own_en = owner ? m1_enable : m0_enable;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] busy_cnt;

    // Counter reads 0 in the first BUSY cycle, so the limit lands on cycle TIMEOUT_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (state == ST_BUSY) begin
            busy_cnt <= busy_cnt + 1'b1;
        end else begin
            busy_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_BUSY) && own_en && !s_ready &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
    end

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= 1'b0;
        end else begin
            state <= next_state;
            owner <= next_owner;
        end
    end

    always_comb begin
        next_state  = state;
        next_owner  = owner;
        capture     = 1'b0;
        release_bus = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m0_enable || m1_enable) begin
                    next_state = ST_BUSY;
                    if (m0_enable && m1_enable) begin
                        next_owner = (ROUND_ROBIN != 0) ? ~last_owner : 1'b0;
                    end else begin
                        next_owner = m1_enable;
                    end
                end
            end
            ST_BUSY: begin
                // Abort outranks both completion and timeout.
                if (!own_en) begin
                    next_state = ST_IDLE;
                end else if (s_ready) begin
                    capture    = 1'b1;
                    next_state = ST_DONE;
                end else if (timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!own_en) begin
                    release_bus = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_enable = (state == ST_BUSY) && own_en;
        grant    = 2'b00;
        if (state == ST_BUSY || state == ST_DONE) begin
            grant = owner ? 2'b10 : 2'b01;
        end
        if ((state != ST_IDLE) && owner) begin
            s_wr_en  = m1_wr_en;
            s_addr   = m1_addr;
            s_i_data = m1_i_data;
            s_be     = m1_be;
        end else begin
            s_wr_en  = m0_wr_en;
            s_addr   = m0_addr;
            s_i_data = m0_i_data;
            s_be     = m0_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
            m0_ready   <= 1'b0;
            m0_o_data  <= '0;
            m0_bus_err <= 1'b0;
            m1_ready   <= 1'b0;
            m1_o_data  <= '0;
            m1_bus_err <= 1'b0;
        end else begin
            if (capture || timeout_hit) begin
                last_owner <= owner;
                if (owner) begin
                    m1_ready   <= 1'b1;
                    m1_o_data  <= capture ? s_o_data : '0;
                    m1_bus_err <= capture ? s_bus_err : 1'b1;
                end else begin
                    m0_ready   <= 1'b1;
                    m0_o_data  <= capture ? s_o_data : '0;
                    m0_bus_err <= capture ? s_bus_err : 1'b1;
                end
            end
            if (release_bus) begin
                m0_ready <= 1'b0;
                m1_ready <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lt100_bus_arbiter.sv
// ============================================================================
// tb_lt100_bus_arbiter : directed self-checking bench, round-robin and
// fixed-priority instances driven from shared stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lt100_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_enable, m0_wr_en, m1_enable, m1_wr_en;
    logic [31:0] m0_addr, m0_i_data, m1_addr, m1_i_data;
    logic [3:0]  m0_be, m1_be;
    logic        s_ready, s_bus_err;
    logic [31:0] s_o_data;

    wire         m0_ready, m0_bus_err, m1_ready, m1_bus_err;
    wire  [31:0] m0_o_data, m1_o_data;
    wire         s_enable, s_wr_en;
    wire  [31:0] s_addr, s_i_data;
    wire  [3:0]  s_be;
    wire  [1:0]  grant;

    wire         fp_m0_ready, fp_m0_bus_err, fp_m1_ready, fp_m1_bus_err;
    wire  [31:0] fp_m0_o_data, fp_m1_o_data;
    wire         fp_s_enable, fp_s_wr_en;
    wire  [31:0] fp_s_addr, fp_s_i_data;
    wire  [3:0]  fp_s_be;
    wire  [1:0]  fp_grant;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    lt100_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .m0_enable(m0_enable), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_i_data(m0_i_data),
        .m0_be(m0_be), .m0_ready(m0_ready), .m0_o_data(m0_o_data), .m0_bus_err(m0_bus_err),
        .m1_enable(m1_enable), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_i_data(m1_i_data),
        .m1_be(m1_be), .m1_ready(m1_ready), .m1_o_data(m1_o_data), .m1_bus_err(m1_bus_err),
        .s_enable(s_enable), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_i_data(s_i_data), .s_be(s_be),
        .s_ready(s_ready), .s_o_data(s_o_data), .s_bus_err(s_bus_err), .grant(grant)
    );

    lt100_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_enable(m0_enable), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_i_data(m0_i_data),
        .m0_be(m0_be), .m0_ready(fp_m0_ready), .m0_o_data(fp_m0_o_data), .m0_bus_err(fp_m0_bus_err),
        .m1_enable(m1_enable), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_i_data(m1_i_data),
        .m1_be(m1_be), .m1_ready(fp_m1_ready), .m1_o_data(fp_m1_o_data), .m1_bus_err(fp_m1_bus_err),
        .s_enable(fp_s_enable), .s_wr_en(fp_s_wr_en), .s_addr(fp_s_addr), .s_i_data(fp_s_i_data),
        .s_be(fp_s_be), .s_ready(s_ready), .s_o_data(s_o_data), .s_bus_err(s_bus_err), .grant(fp_grant)
    );

    // Outputs are checked right after the falling edge, then inputs are changed.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_enable = 1'b0; m0_wr_en = 1'b0; m0_addr = 32'h0; m0_i_data = 32'h0; m0_be = 4'hF;
        m1_enable = 1'b0; m1_wr_en = 1'b0; m1_addr = 32'h0; m1_i_data = 32'h0; m1_be = 4'hF;
        s_ready = 1'b0; s_bus_err = 1'b0; s_o_data = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if ({grant, s_enable, m0_ready, m1_ready, m0_bus_err, m1_bus_err} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b, expected 0000000",
                     {grant, s_enable, m0_ready, m1_ready, m0_bus_err, m1_bus_err});
        end else passed++;
        checks++;
        if ({m0_o_data, m1_o_data} !== 64'h0) begin
            $display("FAIL reset_data: got %h, expected 0", {m0_o_data, m1_o_data});
        end else passed++;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_enable = 1'b1; m0_addr = 32'h0000_0010; m0_wr_en = 1'b0;
        tick();
        checks++;
        if ({s_enable, grant, s_wr_en} !== 4'b1010 || s_addr !== 32'h0000_0010) begin
            $display("FAIL read_t1: got en/grant/wr %b addr %h, expected 1010 addr 00000010",
                     {s_enable, grant, s_wr_en}, s_addr);
        end else passed++;
        tick();
        checks++;
        if ({s_enable, m0_ready} !== 2'b10) begin
            $display("FAIL read_t2: got en/ready %b, expected 10", {s_enable, m0_ready});
        end else passed++;
        tick();
        checks++;
        if ({s_enable, m0_ready} !== 2'b10) begin
            $display("FAIL read_t3: got en/ready %b, expected 10", {s_enable, m0_ready});
        end else passed++;
        s_ready = 1'b1; s_o_data = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({s_enable, m0_ready, grant} !== 4'b0101 || m0_o_data !== 32'hDEAD_BEEF) begin
            $display("FAIL read_t4: got en/ready/grant %b data %h, expected 0101 data deadbeef",
                     {s_enable, m0_ready, grant}, m0_o_data);
        end else passed++;
        s_ready = 1'b0; s_o_data = 32'h0; m0_enable = 1'b0;
        tick();
        checks++;
        if ({m0_ready, grant} !== 3'b000 || m0_o_data !== 32'hDEAD_BEEF) begin
            $display("FAIL read_release: got ready/grant %b data %h, expected 000 data deadbeef",
                     {m0_ready, grant}, m0_o_data);
        end else passed++;
    endtask

    task automatic test_round_robin();
        logic exp_m1;
        do_reset();
        m0_enable = 1'b1; m1_enable = 1'b1;
        exp_m1 = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            checks++;
            if (grant !== (exp_m1 ? 2'b10 : 2'b01)) begin
                $display("FAIL rr_grant%0d: got %b, expected %b", r, grant, exp_m1 ? 2'b10 : 2'b01);
            end else passed++;
            s_ready = 1'b1; s_o_data = 32'hC000_0000 + r;
            tick();
            checks++;
            if ((exp_m1 ? {m1_ready, m0_ready} : {m0_ready, m1_ready}) !== 2'b10 ||
                (exp_m1 ? m1_o_data : m0_o_data) !== 32'hC000_0000 + r) begin
                $display("FAIL rr_ready%0d: got m0/m1 ready %b%b, expected winner only, data %h",
                         r, m0_ready, m1_ready, exp_m1 ? m1_o_data : m0_o_data);
            end else passed++;
            s_ready = 1'b0;
            if (exp_m1) m1_enable = 1'b0; else m0_enable = 1'b0;
            tick();
            if (exp_m1) m1_enable = 1'b1; else m0_enable = 1'b1;
            exp_m1 = ~exp_m1;
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        m0_enable = 1'b1; m1_enable = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            checks++;
            if (fp_grant !== 2'b01) begin
                $display("FAIL fp_grant%0d: got %b, expected 01", r, fp_grant);
            end else passed++;
            s_ready = 1'b1; s_o_data = 32'hF000_0000 + r;
            tick();
            checks++;
            if ({fp_m0_ready, fp_m1_ready} !== 2'b10) begin
                $display("FAIL fp_ready%0d: got m0/m1 ready %b, expected 10", r, {fp_m0_ready, fp_m1_ready});
            end else passed++;
            s_ready = 1'b0; m0_enable = 1'b0;
            tick();
            m0_enable = 1'b1;
        end
    endtask

    task automatic test_write_m1();
        do_reset();
        m1_enable = 1'b1; m1_wr_en = 1'b1; m1_addr = 32'h2000_0004;
        m1_i_data = 32'h1234_5678; m1_be = 4'b0011;
        tick();
        checks++;
        if ({s_enable, s_wr_en, s_be, grant} !== 8'b11_0011_10 || s_i_data !== 32'h1234_5678 ||
            s_addr !== 32'h2000_0004) begin
            $display("FAIL wr_bus: got en/wr/be/grant %b data %h addr %h, expected 11001110 12345678 20000004",
                     {s_enable, s_wr_en, s_be, grant}, s_i_data, s_addr);
        end else passed++;
        checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            $display("FAIL wr_early: got m0/m1 ready %b, expected 00", {m0_ready, m1_ready});
        end else passed++;
        s_ready = 1'b1;
        tick();
        checks++;
        if ({m0_ready, m1_ready, s_enable} !== 3'b010) begin
            $display("FAIL wr_done: got m0/m1 ready/en %b, expected 010", {m0_ready, m1_ready, s_enable});
        end else passed++;
        s_ready = 1'b0; m1_enable = 1'b0;
        tick();
        checks++;
        if ({m0_ready, m1_ready, grant} !== 4'b0000) begin
            $display("FAIL wr_release: got %b, expected 0000", {m0_ready, m1_ready, grant});
        end else passed++;
    endtask

    task automatic test_abort_and_reset();
        do_reset();
        m0_enable = 1'b1;
        tick();
        s_ready = 1'b1; s_o_data = 32'hA5A5_A5A5;
        tick();
        s_ready = 1'b0; m0_enable = 1'b0;
        tick();
        m0_enable = 1'b1;
        tick();
        // Drop enable together with s_ready: the abort must win.
        m0_enable = 1'b0; s_ready = 1'b1; s_o_data = 32'h5555_0000;
        tick();
        s_ready = 1'b0;
        checks++;
        if ({m0_ready, grant} !== 3'b000 || m0_o_data !== 32'hA5A5_A5A5) begin
            $display("FAIL abort: got ready/grant %b data %h, expected 000 data a5a5a5a5",
                     {m0_ready, grant}, m0_o_data);
        end else passed++;
        tick();
        checks++;
        if (m0_ready !== 1'b0) begin
            $display("FAIL abort_late: got ready %b, expected 0", m0_ready);
        end else passed++;
        m1_enable = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b10) begin
            $display("FAIL rst_pre: got grant %b, expected 10", grant);
        end else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, s_enable, m0_ready, m1_ready} !== 5'b0 || m0_o_data !== 32'h0) begin
            $display("FAIL rst_mid: got %b data %h, expected 00000 data 0",
                     {grant, s_enable, m0_ready, m1_ready}, m0_o_data);
        end else passed++;
        m1_enable = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_bus_err();
        do_reset();
        m0_enable = 1'b1;
        tick();
        s_ready = 1'b1; s_bus_err = 1'b1; s_o_data = 32'h0BAD_F00D;
        tick();
        s_ready = 1'b0; s_bus_err = 1'b0;
        checks++;
        if ({m0_ready, m0_bus_err} !== 2'b11) begin
            $display("FAIL err_set: got ready/err %b, expected 11", {m0_ready, m0_bus_err});
        end else passed++;
        tick();
        checks++;
        if ({m0_ready, m0_bus_err} !== 2'b11 || m0_o_data !== 32'h0BAD_F00D) begin
            $display("FAIL err_hold: got ready/err %b data %h, expected 11 data 0badf00d",
                     {m0_ready, m0_bus_err}, m0_o_data);
        end else passed++;
        m0_enable = 1'b0;
        tick();
        checks++;
        if ({m0_ready, m0_bus_err} !== 2'b01) begin
            $display("FAIL err_release: got ready/err %b, expected 01", {m0_ready, m0_bus_err});
        end else passed++;
        m0_enable = 1'b1;
        tick();
        s_ready = 1'b1; s_o_data = 32'h0000_0042;
        tick();
        s_ready = 1'b0;
        checks++;
        if ({m0_ready, m0_bus_err} !== 2'b10 || m0_o_data !== 32'h0000_0042) begin
            $display("FAIL err_clear: got ready/err %b data %h, expected 10 data 00000042",
                     {m0_ready, m0_bus_err}, m0_o_data);
        end else passed++;
        m0_enable = 1'b0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        m0_enable = 1'b1;
        tick();
        s_ready = 1'b1; s_o_data = 32'h1111_2222;
        tick();
        s_ready = 1'b0; m0_enable = 1'b0;
        tick();
        m0_enable = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            checks++;
            if ({s_enable, m0_ready} !== 2'b10) begin
                $display("FAIL to_busy%0d: got en/ready %b, expected 10", c, {s_enable, m0_ready});
            end else passed++;
        end
        tick();
        checks++;
        if ({s_enable, m0_ready, m0_bus_err} !== 3'b011 || m0_o_data !== 32'h0) begin
            $display("FAIL to_fire: got en/ready/err %b data %h, expected 011 data 0",
                     {s_enable, m0_ready, m0_bus_err}, m0_o_data);
        end else passed++;
        m0_enable = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_write_m1();
        test_abort_and_reset();
        test_bus_err();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lt100_bus_arbiter.md
Name: lt100_bus_arbiter

Overview:
Two-master arbiter that shares the single Little Timmy 100 common bus (bus fabric slave port) between two requesters, e.g. CPU fetch and data ports, or CPU and a DMA engine. Uses the same enable/ready bus protocol on both sides: a master holds enable until it sees ready, then drops enable. Round-robin or fixed-priority grant. Read data and bus_err are registered and held toward the master until it releases the bus.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports; be width = DATA_WIDTH/8
ROUND_ROBIN, 1, 1 = round-robin between M0/M1; 0 = fixed priority, M0 wins ties
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
m0_enable  in  1  master 0 request, held until m0_ready then dropped
m0_wr_en  in  1  master 0 write
m0_addr  in  ADDR_WIDTH  master 0 address
m0_i_data  in  DATA_WIDTH  master 0 write data
m0_be  in  DATA_WIDTH/8  master 0 byte enables
m0_ready  out  1  master 0 transfer complete
m0_o_data  out  DATA_WIDTH  master 0 read data
m0_bus_err  out  1  master 0 error, valid with m0_ready
m1_*  same set and widths as m0_*, for master 1
s_enable  out  1  to bus fabric enable
s_wr_en, s_addr, s_i_data, s_be  out  as master  muxed from owner
s_ready  in  1  fabric ready
s_o_data  in  DATA_WIDTH  fabric read data
s_bus_err  in  1  fabric error
grant  out  2  one-hot current owner (bit0 = M0), 0 when idle

Behaviour:
- Reset (async, rst_n low): state IDLE, grant=0, last_owner=M1 (so M0 wins first tie), all m*_ready=0, m*_o_data=0, m*_bus_err=0, s_enable=0.
- States: IDLE, BUSY, DONE.
- IDLE: if any m*_enable is high, register the owner and go to BUSY next cycle. Round-robin: on a tie, pick the master other than last_owner. Fixed mode: on a tie, M0. If there is no request, stay.
- BUSY: s_enable = owner's m_enable. s_wr_en/s_addr/s_i_data/s_be are combinational muxes from the owner's inputs. The non-owner's inputs are ignored and its ready stays 0.
  - s_ready sampled high: capture s_o_data and s_bus_err into the owner's o_data/bus_err registers, set owner ready=1, set last_owner=owner, go to DONE.
  - Owner drops enable before s_ready (abort): go to IDLE, no ready, data registers unchanged.
  - If s_ready and the owner dropping enable occur in the same cycle, the abort takes priority.
- DONE: s_enable=0, so the fabric clears its ready. Owner ready is held at 1 with stable data. When the owner's enable is sampled low: clear ready and go to IDLE.
  - The other master's pending request is arbitrated in IDLE on the following cycle.
  - Back-to-back grants therefore cost one IDLE cycle.
- Latency:
  - Request in IDLE at cycle t: s_enable is high from t+1.
  - s_ready at cycle r: m_ready is high from r+1.
  - Minimum transaction is 3 cycles plus slave latency.
- Output rules:
  - m*_o_data and m*_bus_err change only on capture and are held otherwise.
  - s_* outputs other than s_enable are don't-care when s_enable=0, but are driven from M0 when idle.
  - grant reflects the registered owner in BUSY and DONE.
- Reset asserted mid-transaction: immediate return to reset values; no ready is generated for the in-flight access.

Optional Feature:
ARB_TIMEOUT_EN
- With the macro:
  - An 8+ bit counter clears on entering BUSY and increments every BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without s_ready: deassert s_enable, set owner bus_err=1, o_data=0, ready=1, go to DONE.
  - s_ready arriving in that same cycle wins over the timeout.
- Without the macro: no counter, and BUSY waits indefinitely.

Test Plan:
- Single M0 read: m0_enable at t, addr 0x00000010; fabric returns 0xDEADBEEF with s_ready at t+3 -> s_enable high t+1..t+3, m0_ready high from t+4, m0_o_data=0xDEADBEEF, grant=01.
- Simultaneous M0/M1 requests, ROUND_ROBIN=1, repeated 4 times -> grants alternate M0,M1,M0,M1. Repeat with ROUND_ROBIN=0 while M0 re-requests every time -> M0 granted all 4 times, M1 starved.
- M1 write 0x12345678, be=4'b0011, addr 0x20000004 -> s_wr_en=1, s_be=0011, s_i_data matches; m1_ready is one cycle after s_ready; m0_ready stays 0 throughout.
- Owner drops enable in BUSY before s_ready -> back to IDLE next cycle, no ready, o_data unchanged. Also test rst_n pulsed low mid-BUSY -> all outputs 0 immediately.
- Fabric returns s_bus_err=1 with s_ready -> owner bus_err=1 and ready=1 held until enable drops; the next transaction with s_bus_err=0 clears it.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, s_ready never asserted -> after 8 BUSY cycles s_enable=0, m0_bus_err=1, m0_ready=1, m0_o_data=0.
